fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Forwarding and hazard-detection controller for the four-stage ID → EXE → MEM → WB integer pipeline.
- Tracks destination tags of the two instructions ahead of the one in ID.
- Produces the registered operand-select codes that the EXE stage uses to choose between the register-file value, the MEM-stage ALU result and the WB write-back value.
- Raises a load-use stall that freezes PC and the IF/ID register and inserts a bubble into EXE.

## Interface
Parameters:
- REG_AW, 5, register address width.

Ports (all 1-bit unless stated):
- clk, input: pipeline clock, rising edge.
- rst_n, input: asynchronous active-low reset.
- id_valid, input: ID holds a live instruction.
- id_src1, input, REG_AW: first source register of the ID instruction.
- id_src2, input, REG_AW: second source register of the ID instruction.
- id_use_src1, input: ID instruction reads src1.
- id_use_src2, input: ID instruction reads src2 (0 for immediate forms).
- id_dest, input, REG_AW: destination register of the ID instruction.
- id_wb_en, input: ID instruction writes the register file.
- id_mem_read, input: ID instruction is a load.
- flush, input: squash the ID instruction (taken branch/jump).
- stall, output: combinational; freeze PC and IF/ID; a bubble enters EXE.
- src1_mux, output, 2: registered select for EXE operand 1.
- src2_mux, output, 2: registered select for EXE operand 2.

Clock and reset are fixed: one clock `clk`; reset `rst_n` is asynchronous, active-low.

## Operation
- Select encoding, both operands: 0 = register-file value; 1 = MEM-stage ALU result; 2 = WB write-back value; 3 = reserved, never driven.
- Internal tracking registers:
  - E slot: dest, wb, ld for the instruction now in EXE.
  - M slot: dest, wb for the instruction now in MEM.
- Qualified write: wb && dest != 0. Register 0 never forwards and never stalls.
- Per source s (considered only if id_valid && id_use_s && !flush):
  - E-qualified match with ld = 0 → next select 1.
  - else E-qualified match with ld = 1 → hazard.
  - else M-qualified match → next select 2.
  - else → next select 0.
  - E-slot priority over M slot (newest value wins).
- stall = hazard on src1 OR src2.
- Each rising edge:
  - M ← E.
  - If stall, flush or !id_valid: E ← bubble (wb = 0, ld = 0, dest = 0) and both selects ← 0.
  - Otherwise E ← {id_dest, id_wb_en, id_mem_read} and selects ← computed values.
- After a stall, the load sits in M. The dependent instruction then gets select 2 and reads the load data from WB. Load-use penalty is exactly one cycle.
- Instructions three or more apart need no select. The register file is write-before-read; that is outside this block.
- flush takes priority over stall: a squashed instruction never stalls.

## Timing
- Reset values: E and M slots cleared (wb = 0, ld = 0, dest = 0); src1_mux = 0; src2_mux = 0; stall = 0. Reset acts immediately, including mid-stall.
- src*_mux are valid during the cycle the instruction occupies EXE: one cycle after it was presented in ID.
- stall is same-cycle combinational from the ID inputs and the E slot, with no register in the path.
- Back-to-back loads to the same register:
  - A consumer of the second load stalls once.
  - The first load's value is shadowed by E-slot priority.
- A stall lasts at most one cycle per ID instruction, because a bubble always follows.

## Configuration
- FWD_HAZARD_FORWARDING_EN defined: behaviour as above.
- FWD_HAZARD_FORWARDING_EN undefined:
  - src*_mux are tied to 0.
  - stall asserts on any E- or M-qualified match, load or not.
  - A dependent instruction waits until the producer reaches WB: 2 stall cycles for distance 1, 1 stall cycle for distance 2.

## Test plan
- ALU chain: add r3 then sub r4 = r3 − r1 on the next cycle → src1_mux = 1 during sub's EXE, stall never asserts.
- Distance-2 dependency: add r5, nop, or r6 = r2 | r5 → src2_mux = 2 during or's EXE; src1_mux = 0.
- Load-use: lw r7 then add r8 = r7 + r7:
  - stall = 1 for exactly one cycle.
  - Bubble in EXE with selects 0.
  - Next cycle src1_mux = src2_mux = 2.
- r0 and immediate: add r0 then addi r9 = r0 + 5 (id_use_src2 = 0) → both selects 0, no stall. Repeat with the producer writing r2 and id_use_src2 = 0 while id_src2 = 2 → src2_mux = 0.
- Flush versus stall: lw r7 with flush asserted on the dependent ID instruction → stall = 0, bubble enters, selects 0.
- Async reset: assert rst_n = 0 mid-stall → stall and selects drop to 0 without a clock edge. FWD_HAZARD_FORWARDING_EN undefined build, distance-1 ALU dependency → stall is 1 for exactly 2 cycles, then selects 0.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding / load-use hazard controller for the ID->EXE->MEM->WB pipeline.
// Define FWD_HAZARD_FORWARDING_EN to enable forwarding; otherwise dependents stall until WB.
module fwd_hazard_unit #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_use_src1,
    input  logic              id_use_src2,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        src1_mux,
    output logic [1:0]        src2_mux
);

`ifdef FWD_HAZARD_FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    logic [REG_AW-1:0] e_dest, m_dest;
    logic              e_wb, e_ld, m_wb;
    logic              e_q, m_q;
    logic              hz1, hz2;
    logic [1:0]        sel1_d, sel2_d;

    // Register 0 is hard-wired, so writes to it never count as producers.
    assign e_q = e_wb && (e_dest != '0);
    assign m_q = m_wb && (m_dest != '0);

    // Returns {hazard, select}. E slot is checked first so the newest value wins.
    function automatic logic [2:0] resolve(
        input logic              live,
        input logic [REG_AW-1:0] src,
        input logic              eq,
        input logic [REG_AW-1:0] ed,
        input logic              eld,
        input logic              mq,
        input logic [REG_AW-1:0] md
    );
        logic       e_hit, m_hit, hz;
        logic [1:0] sel;
        e_hit = live && eq && (ed == src);
        m_hit = live && mq && (md == src);
        // Without forwarding any in-flight producer blocks until it reaches WB.
        hz    = (e_hit && eld) || (!FWD_EN && (e_hit || m_hit));
        sel   = SEL_RF;
        if (FWD_EN) begin
            if (e_hit && !eld)
                sel = SEL_MEM;
            else if (!e_hit && m_hit)
                sel = SEL_WB;
        end
        return {hz, sel};
    endfunction

    always_comb begin
        {hz1, sel1_d} = resolve(id_valid && id_use_src1 && !flush, id_src1,
                                e_q, e_dest, e_ld, m_q, m_dest);
        {hz2, sel2_d} = resolve(id_valid && id_use_src2 && !flush, id_src2,
                                e_q, e_dest, e_ld, m_q, m_dest);
    end

    assign stall = hz1 || hz2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_dest   <= '0;
            e_wb     <= 1'b0;
            e_ld     <= 1'b0;
            m_dest   <= '0;
            m_wb     <= 1'b0;
            src1_mux <= SEL_RF;
            src2_mux <= SEL_RF;
        end else begin
            m_dest <= e_dest;
            m_wb   <= e_wb;
            if (stall || flush || !id_valid) begin
                e_dest   <= '0;
                e_wb     <= 1'b0;
                e_ld     <= 1'b0;
                src1_mux <= SEL_RF;
                src2_mux <= SEL_RF;
            end else begin
                e_dest   <= id_dest;
                e_wb     <= id_wb_en;
                e_ld     <= id_mem_read;
                src1_mux <= sel1_d;
                src2_mux <= sel2_d;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit; expected selects are queued at drive time
// and popped once the instruction reaches EXE. Follows FWD_HAZARD_FORWARDING_EN.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_src1, id_use_src2, id_wb_en, id_mem_read, flush;
    logic [4:0] id_src1, id_src2, id_dest;
    logic       stall;
    logic [1:0] src1_mux, src2_mux;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [3:0] exp_q[$];

    fwd_hazard_unit #(.REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .flush(flush), .stall(stall), .src1_mux(src1_mux), .src2_mux(src2_mux)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One ID cycle: drive, check comb stall, queue selects, clock, check selects.
    task automatic step(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic u1, input logic u2, input logic [4:0] d,
                        input logic wb, input logic ld, input logic fl,
                        input logic xst, input logic [1:0] x1, input logic [1:0] x2,
                        input string tag);
        logic [3:0] e;
        id_valid = v; id_src1 = s1; id_src2 = s2; id_use_src1 = u1; id_use_src2 = u2;
        id_dest = d; id_wb_en = wb; id_mem_read = ld; flush = fl;
        #1;
        chk({tag, "/stall"}, {1'b0, stall}, {1'b0, xst});
        exp_q.push_back({x1, x2});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "/src1_mux"}, src1_mux, e[3:2]);
        chk({tag, "/src2_mux"}, src2_mux, e[1:0]);
    endtask

    task automatic nop(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic drain();
        nop("drain0");
        nop("drain1");
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b1; id_src1 = 5'd3; id_src2 = 5'd3; id_use_src1 = 1'b1; id_use_src2 = 1'b1;
        id_dest = 5'd3; id_wb_en = 1'b1; id_mem_read = 1'b1; flush = 1'b0;
        #12;
        chk("reset/stall", {1'b0, stall}, 2'd0);
        chk("reset/src1_mux", src1_mux, 2'd0);
        chk("reset/src2_mux", src2_mux, 2'd0);
        id_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU chain: add r3 = r1 + r2; sub r4 = r3 - r1
        step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, "add_r3");
`ifdef FWD_HAZARD_FORWARDING_EN
        step(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 1, 0, "sub_r4");
`else
        step(1, 3, 1, 1, 1, 4, 1, 0, 0, 1, 0, 0, "sub_r4_stall1");
        step(1, 3, 1, 1, 1, 4, 1, 0, 0, 1, 0, 0, "sub_r4_stall2");
        step(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, 0, "sub_r4_go");
`endif
        drain();

        // Distance 2: add r5; nop; or r6 = r2 | r5
        step(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, "add_r5");
        nop("gap");
`ifdef FWD_HAZARD_FORWARDING_EN
        step(1, 2, 5, 1, 1, 6, 1, 0, 0, 0, 0, 2, "or_r6");
`else
        step(1, 2, 5, 1, 1, 6, 1, 0, 0, 1, 0, 0, "or_r6_stall");
        step(1, 2, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, "or_r6_go");
`endif
        drain();

        // Load-use: lw r7; add r8 = r7 + r7
        step(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, "lw_r7");
`ifdef FWD_HAZARD_FORWARDING_EN
        step(1, 7, 7, 1, 1, 8, 1, 0, 0, 1, 0, 0, "add_r8_stall");
        step(1, 7, 7, 1, 1, 8, 1, 0, 0, 0, 2, 2, "add_r8_go");
`else
        step(1, 7, 7, 1, 1, 8, 1, 0, 0, 1, 0, 0, "add_r8_stall1");
        step(1, 7, 7, 1, 1, 8, 1, 0, 0, 1, 0, 0, "add_r8_stall2");
        step(1, 7, 7, 1, 1, 8, 1, 0, 0, 0, 0, 0, "add_r8_go");
`endif
        drain();

        // r0 never forwards; unused src2 never forwards
        step(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, "add_r0");
        step(1, 0, 0, 1, 0, 9, 1, 0, 0, 0, 0, 0, "addi_r9");
        drain();
        step(1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0, "add_r2");
        step(1, 1, 2, 1, 0, 10, 1, 0, 0, 0, 0, 0, "addi_r10");
        drain();

        // Flush beats stall
        step(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, "lw_r7_f");
        step(1, 7, 7, 1, 1, 8, 1, 0, 1, 0, 0, 0, "add_r8_flush");
        drain();

        // Async reset mid-stall; lw r7 = [r1] depends on add r1 so src1_mux is live
        step(1, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, "add_r1");
`ifdef FWD_HAZARD_FORWARDING_EN
        step(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 1, 0, "lw_r1");
`else
        step(1, 1, 0, 1, 0, 7, 1, 1, 0, 1, 0, 0, "lw_r1_stall1");
        step(1, 1, 0, 1, 0, 7, 1, 1, 0, 1, 0, 0, "lw_r1_stall2");
        step(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, "lw_r1_go");
`endif
        id_valid = 1; id_src1 = 7; id_src2 = 7; id_use_src1 = 1; id_use_src2 = 1;
        id_dest = 8; id_wb_en = 1; id_mem_read = 0; flush = 0;
        #1;
        chk("midstall/stall", {1'b0, stall}, 2'd1);
`ifdef FWD_HAZARD_FORWARDING_EN
        chk("midstall/src1_mux", src1_mux, 2'd1);
`else
        chk("midstall/src1_mux", src1_mux, 2'd0);
`endif
        rst_n = 1'b0;
        #1;
        chk("async_rst/stall", {1'b0, stall}, 2'd0);
        chk("async_rst/src1_mux", src1_mux, 2'd0);
        chk("async_rst/src2_mux", src2_mux, 2'd0);
        id_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pipeline works again after reset
        step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, "post_add_r3");
`ifdef FWD_HAZARD_FORWARDING_EN
        step(1, 4, 3, 1, 1, 4, 1, 0, 0, 0, 0, 1, "post_sub_r4");
`else
        step(1, 4, 3, 1, 1, 4, 1, 0, 0, 1, 0, 0, "post_sub_r4_stall");
`endif
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
